mdu_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit for the pipelined MIPS core, executed from EX.

---
 rtl/mdu_iter.sv | 148 ++++++++++++++
 tb/tb_mdu_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage: signed/unsigned MULT and DIV
// with a start/ready handshake, flush abort and defined divide-by-zero results.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + MUL_STEP;

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} stateT;

    stateT              state;
    logic [1:0]         opReg;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               negRes;
    logic               negRem;
    logic               divZero;

    logic               isDiv;
    logic               isSigned;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [SW-1:0]      mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    assign isDiv    = opReg[1];
    assign isSigned = ~opReg[0];
    assign magA     = (isSigned && aReg[WIDTH-1]) ? -aReg : aReg;
    assign magB     = (isSigned && bReg[WIDTH-1]) ? -bReg : bReg;

    // Multiply: acc holds {partial product, remaining multiplier bits}; shift right by MUL_STEP.
    assign mulSum  = SW'(acc[2*WIDTH-1:WIDTH]) + SW'(mcand) * SW'(acc[MUL_STEP-1:0]);
    assign mulNext = {mulSum, acc[WIDTH-1:MUL_STEP]};

    // Divide: acc holds {remainder, dividend/quotient}; restoring step, one bit per cycle.
    assign divShift = acc[2*WIDTH-1:WIDTH-1];
    assign divDiff  = divShift - {1'b0, mcand};
    assign divNext  = (divShift >= {1'b0, mcand}) ? {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                                  : {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign prodFix = negRes ? -acc : acc;
    assign quoFix  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            opReg       <= '0;
            aReg        <= '0;
            bReg        <= '0;
            acc         <= '0;
            mcand       <= '0;
            cnt         <= '0;
            negRes      <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            opReg       <= op;
                            aReg        <= src_a;
                            bReg        <= src_b;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= PREP;
                        end
                    end
                    PREP: begin
                        negRes  <= isSigned & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
                        negRem  <= isSigned & aReg[WIDTH-1];
                        divZero <= isDiv && (bReg == '0);
                        if (isDiv) begin
                            acc   <= {{WIDTH{1'b0}}, magA};
                            mcand <= magB;
                            cnt   <= CW'(WIDTH);
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, magB};
                            mcand <= magA;
                            cnt   <= CW'(WIDTH / MUL_STEP);
                        end
                        state <= ITER;
                    end
                    ITER: begin
                        acc <= isDiv ? divNext : mulNext;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) state <= FIX;
                    end
                    FIX: begin
                        if (divZero) begin
                            hi          <= aReg;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (isDiv) begin
                            hi <= remFix;
                            lo <= quoFix;
                        end else begin
                            hi <= prodFix[2*WIDTH-1:WIDTH];
                            lo <= prodFix[WIDTH-1:0];
                        end
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter (WIDTH=32, MUL_STEP=2): directed table, corner sequences and
// random operations checked against an arithmetic reference model.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         busy;
    logic         ready;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divByZero;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vecT;

    vecT tbl[12];

    mdu_iter #(.WIDTH(W), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
        .src_a(srcA), .src_b(srcB), .busy(busy), .ready(ready),
        .hi(hi), .lo(lo), .div_by_zero(divByZero)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
        logic [63:0] p;
        longint sa, sb, q, r;
        z = 1'b0;
        if (!o[1]) begin
            if (!o[0]) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else       p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
            h = a;
            l = '1;
            z = 1'b1;
        end else if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Called 1 time unit after a rising edge; returns in the ready cycle at the same offset.
    task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l, output logic z,
                         output int lat, output int busyCnt);
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        srcA = $urandom;
        srcB = $urandom;
        lat = 1;
        busyCnt = 0;
        while (!ready && lat < 200) begin
            if (busy) busyCnt++;
            @(posedge clk); #1;
            lat++;
        end
        h = hi; l = lo; z = divByZero;
    endtask

    task automatic checkOp(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez);
        logic [W-1:0] h, l;
        logic z;
        int lat, bc;
        runOp(o, a, b, h, l, z, lat, bc);
        chk({name, " latency"}, 64'(lat), o[1] ? 64'd35 : 64'd19);
        chk({name, " busy_cycles"}, 64'(bc), o[1] ? 64'd34 : 64'd18);
        chk({name, " hi"}, 64'(h), 64'(eh));
        chk({name, " lo"}, 64'(l), 64'(el));
        chk({name, " dbz"}, 64'(z), 64'(ez));
        @(posedge clk); #1;
        chk({name, " ready_pulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        logic [W-1:0] h, l, eh, el, prevHi, prevLo;
        logic z, ez;
        int lat, bc, rdyCnt;

        tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[4]  = '{2'b11, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
        tbl[7]  = '{2'b10, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1};
        tbl[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{2'b01, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0};
        tbl[10] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tbl[11] = '{2'b00, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

        #12;
        chk("reset busy", 64'(busy), 0);
        chk("reset ready", 64'(ready), 0);
        chk("reset hi", 64'(hi), 0);
        chk("reset lo", 64'(lo), 0);
        chk("reset dbz", 64'(divByZero), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            checkOp($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz);

        // Back-to-back: second start lands in the first op's ready cycle.
        runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, z, lat, bc);
        chk("b2b first latency", 64'(lat), 19);
        chk("b2b first lo", 64'(l), 64'h1);
        runOp(2'b00, 32'h80000000, 32'h80000000, h, l, z, lat, bc);
        chk("b2b second latency", 64'(lat), 19);
        chk("b2b second hi", 64'(h), 64'h40000000);
        chk("b2b second lo", 64'(l), 0);
        @(posedge clk); #1;

        // Flush mid-divide, with an ignored start while busy.
        prevHi = hi; prevLo = lo;
        op = 2'b10; srcA = 32'd100; srcB = 32'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        op = 2'b01; srcA = 32'd5; srcB = 32'd5; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("flush busy_before", 64'(busy), 1);
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush busy_after", 64'(busy), 0);
        rdyCnt = 0;
        bc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rdyCnt++;
            if (busy) bc++;
        end
        chk("flush no_ready", 64'(rdyCnt), 0);
        chk("flush no_queued", 64'(bc), 0);
        chk("flush hi_hold", 64'(hi), 64'(prevHi));
        chk("flush lo_hold", 64'(lo), 64'(prevLo));

        // start and flush together in IDLE.
        op = 2'b00; srcA = 32'd3; srcB = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("start_flush busy", 64'(busy), 0);
        rdyCnt = 0;
        repeat (25) begin @(posedge clk); #1; if (ready || busy) rdyCnt++; end
        chk("start_flush idle", 64'(rdyCnt), 0);

        // Asynchronous reset in the middle of a multiply.
        checkOp("pre_reset", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        checkOp("pre_reset_dbz", 2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);
        op = 2'b00; srcA = 32'd5; srcB = 32'd9; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        chk("async_rst busy", 64'(busy), 0);
        chk("async_rst ready", 64'(ready), 0);
        chk("async_rst hi", 64'(hi), 0);
        chk("async_rst lo", 64'(lo), 0);
        chk("async_rst dbz", 64'(divByZero), 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        checkOp("post_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0] ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = '1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            refModel(ro, ra, rb, eh, el, ez);
            checkOp($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ez);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
